alarm_seg_capture: RTL



---
 rtl/alarm_seg_capture.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/alarm_seg_capture.sv
// Purpose : rebuild BCD time from a multiplexed 7-segment scan bus; publish only stable frames.
// Latency : input register, then commit on digit exit; time_bcd/time_valid 3 cycles after the final commit.
// Backpress: none; the scan source is free-running and cannot be stalled.
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   seg_in[6:0]  - segments a..g (bit0 = a), active-high
//   dig_sel[N-1:0] - one-hot digit enable, bit0 = rightmost digit, all-zero = blanking gap
//   time_bcd     - published digits, nibble i = digit i (4'hA = blank digit)
//   time_valid   - one-cycle pulse when time_bcd (and dp_bits) change
//   seg_err      - set when a frame is discarded, cleared by the next accepted frame
//   frame_lock   - high while the last STABLE_SCANS frames matched
//
// Optional macro ALARM_SEG_CAPTURE_DP_EN adds dp_in (decimal point per digit) and
// dp_bits (published with time_bcd); dp then takes part in the frame compare.

module alarm_seg_capture #(
  parameter int NUM_DIGITS   = 4,
  parameter int STABLE_SCANS = 2,
  parameter int MIN_DWELL    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
`ifdef ALARM_SEG_CAPTURE_DP_EN
  input  logic                    dp_in,
  output logic [NUM_DIGITS-1:0]   dp_bits,
`endif
  output logic [4*NUM_DIGITS-1:0] time_bcd,
  output logic                    time_valid,
  output logic                    seg_err,
  output logic                    frame_lock
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_COMPARE = 2'd2
  } state_t;

  localparam logic [NUM_DIGITS-1:0] DIG_ONE   = NUM_DIGITS'(1);
  localparam logic [7:0]            DWELL_MAX = 8'(MIN_DWELL);
  localparam logic [3:0]            MATCH_MAX = 4'(STABLE_SCANS);

  // More than one bit set: x & (x-1) clears the lowest set bit.
  function automatic logic multi_hot(input logic [NUM_DIGITS-1:0] d);
    return |(d & (d - DIG_ONE));
  endfunction

  // Returns {illegal, nibble}. Blank (all segments off) is legal and maps to 4'hA.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h3F:   r = {1'b0, 4'h0};
      7'h06:   r = {1'b0, 4'h1};
      7'h5B:   r = {1'b0, 4'h2};
      7'h4F:   r = {1'b0, 4'h3};
      7'h66:   r = {1'b0, 4'h4};
      7'h6D:   r = {1'b0, 4'h5};
      7'h7D:   r = {1'b0, 4'h6};
      7'h07:   r = {1'b0, 4'h7};
      7'h7F:   r = {1'b0, 4'h8};
      7'h6F:   r = {1'b0, 4'h9};
      7'h00:   r = {1'b0, 4'hA};
      default: r = {1'b1, 4'hF};
    endcase
    return r;
  endfunction

  // Input stage (same-clock source, no synchronizer).
  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   dig_q;

  // dig_q/seg_q delayed by one: the digit currently being held and its latest segments.
  logic [NUM_DIGITS-1:0]   cur_dig_q;
  logic [6:0]              cur_seg_q;
  logic [7:0]              dwell_q, dwell_d;

  // Frame assembly.
  state_t                  state_q;
  logic [NUM_DIGITS-1:0]   mask_q;
  logic [4*NUM_DIGITS-1:0] work_q;
  logic [4*NUM_DIGITS-1:0] cand_q;
  logic [3:0]              match_q;

  // Registered outputs.
  logic [4*NUM_DIGITS-1:0] time_bcd_q;
  logic                    time_valid_q;
  logic                    seg_err_q;
  logic                    frame_lock_q;

`ifdef ALARM_SEG_CAPTURE_DP_EN
  logic                    dp_q;
  logic                    cur_dp_q;
  logic [NUM_DIGITS-1:0]   work_dp_q;
  logic [NUM_DIGITS-1:0]   cand_dp_q;
  logic [NUM_DIGITS-1:0]   dp_bits_q;
`endif

  // Combinational helpers.
  logic                    dig_multi;
  logic                    dig_one;
  logic                    cur_one;
  logic                    same_dig;
  logic                    commit;
  logic                    commit_bad;
  logic [3:0]              commit_nib;
  logic [NUM_DIGITS-1:0]   mask_base;
  logic [NUM_DIGITS-1:0]   mask_new;
  logic                    mask_full;
  logic                    dbl_commit;
  logic                    discard;
  logic                    frame_eq;
  logic                    pub_diff;

  always_comb begin
    dig_multi = multi_hot(dig_q);
    dig_one   = (dig_q != '0) && !dig_multi;
    cur_one   = (cur_dig_q != '0) && !multi_hot(cur_dig_q);
    same_dig  = (dig_q == cur_dig_q);

    // Dwell counts cycles the held one-hot value has been present, saturating.
    dwell_d = 8'd0;
    if (same_dig && dig_one) begin
      dwell_d = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + 8'd1;
    end else if (dig_one) begin
      dwell_d = 8'd1;
    end

    // A digit commits on the cycle the bus leaves it (to another digit, a gap,
    // or a multi-hot value), provided it was held long enough.
    commit = !same_dig && cur_one && (dwell_q == DWELL_MAX);
    {commit_bad, commit_nib} = decode(cur_seg_q);

    // COMPARE clears the mask, so a commit landing in that cycle starts a new frame.
    mask_base  = (state_q == S_COMPARE) ? '0 : mask_q;
    dbl_commit = commit && |(mask_base & cur_dig_q);
    mask_new   = mask_base | cur_dig_q;
    mask_full  = &mask_new;

    // Discard outranks a commit that would complete the frame.
    discard = dig_multi || (commit && (commit_bad || dbl_commit));

`ifdef ALARM_SEG_CAPTURE_DP_EN
    frame_eq = (work_q == cand_q) && (work_dp_q == cand_dp_q);
    pub_diff = (cand_q != time_bcd_q) || (cand_dp_q != dp_bits_q);
`else
    frame_eq = (work_q == cand_q);
    pub_diff = (cand_q != time_bcd_q);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q        <= '0;
      dig_q        <= '0;
      cur_dig_q    <= '0;
      cur_seg_q    <= '0;
      dwell_q      <= '0;
      state_q      <= S_IDLE;
      mask_q       <= '0;
      work_q       <= '0;
      cand_q       <= '0;
      match_q      <= '0;
      time_bcd_q   <= '0;
      time_valid_q <= 1'b0;
      seg_err_q    <= 1'b0;
      frame_lock_q <= 1'b0;
`ifdef ALARM_SEG_CAPTURE_DP_EN
      dp_q         <= 1'b0;
      cur_dp_q     <= 1'b0;
      work_dp_q    <= '0;
      cand_dp_q    <= '0;
      dp_bits_q    <= '0;
`endif
    end else begin
      seg_q     <= seg_in;
      dig_q     <= dig_sel;
      cur_dig_q <= dig_q;
      cur_seg_q <= seg_q;
      dwell_q   <= dwell_d;
`ifdef ALARM_SEG_CAPTURE_DP_EN
      dp_q      <= dp_in;
      cur_dp_q  <= dp_q;
`endif

      // Publish stage: acts on the match count settled by the previous COMPARE.
      time_valid_q <= 1'b0;
      if (discard) begin
        seg_err_q    <= 1'b1;
        frame_lock_q <= 1'b0;
      end else if (match_q == MATCH_MAX) begin
        seg_err_q    <= 1'b0;
        frame_lock_q <= 1'b1;
        if (pub_diff) begin
          time_bcd_q   <= cand_q;
          time_valid_q <= 1'b1;
`ifdef ALARM_SEG_CAPTURE_DP_EN
          dp_bits_q    <= cand_dp_q;
`endif
        end
      end else begin
        frame_lock_q <= 1'b0;
      end

      // Frame FSM.
      if (discard) begin
        mask_q  <= '0;
        match_q <= '0;
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE, S_COLLECT: begin
            if (commit) begin
              for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cur_dig_q[i]) begin
                  work_q[4*i +: 4] <= commit_nib;
`ifdef ALARM_SEG_CAPTURE_DP_EN
                  work_dp_q[i]     <= cur_dp_q;
`endif
                end
              end
              mask_q  <= mask_new;
              state_q <= mask_full ? S_COMPARE : S_COLLECT;
            end
          end
          S_COMPARE: begin
            if (frame_eq) begin
              match_q <= (match_q == MATCH_MAX) ? match_q : match_q + 4'd1;
            end else begin
              cand_q  <= work_q;
`ifdef ALARM_SEG_CAPTURE_DP_EN
              cand_dp_q <= work_dp_q;
`endif
              match_q <= 4'd1;
            end
            if (commit) begin
              for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cur_dig_q[i]) begin
                  work_q[4*i +: 4] <= commit_nib;
`ifdef ALARM_SEG_CAPTURE_DP_EN
                  work_dp_q[i]     <= cur_dp_q;
`endif
                end
              end
              mask_q <= mask_new;
            end else begin
              mask_q <= '0;
            end
            state_q <= (commit && mask_full) ? S_COMPARE : S_COLLECT;
          end
          default: begin
            mask_q  <= '0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign time_bcd   = time_bcd_q;
  assign time_valid = time_valid_q;
  assign seg_err    = seg_err_q;
  assign frame_lock = frame_lock_q;
`ifdef ALARM_SEG_CAPTURE_DP_EN
  assign dp_bits    = dp_bits_q;
`endif

endmodule
